// File: rtl/tribus_pkg.sv
// Shared types and helpers for the tristate bus reader.
// Holds the FSM state type, bus width and round-robin pick.
package tribus_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SAMPLE,
    TURN
  } tribus_state_t;

  // start is the first slot examined; callers keep it one past the last winner
  function automatic int rr_pick(
    input logic [7:0] req,
    input logic [2:0] start,
    input int         n
  );
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = int'(start) + i;
      if (idx >= n) idx -= n;
      if (i < n && !found && req[idx[2:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tribus_fifo.sv
// Synchronous FIFO for tagged bus bytes.
// Head holds the last popped entry while empty.
module tribus_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] last;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tribus_reader.sv
// Tristate bus reader: grant, settle, sample, turnaround, FIFO.
// TRIBUS_READER_STATS_EN adds stat_bytes and stat_stall counters.
module tribus_reader
  import tribus_pkg::*;
#(
  parameter int N_DRV = 4,
  parameter int DEPTH = 4,
  localparam int SRC_W = $clog2(N_DRV)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_DRV-1:0] req,
  output logic [N_DRV-1:0] en,
  input  logic [BUS_W-1:0] bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic [SRC_W-1:0] out_src,
  output logic             full
`ifdef TRIBUS_READER_STATS_EN
  ,
  output logic [15:0]      stat_bytes,
  output logic [15:0]      stat_stall
`endif
);

  tribus_state_t    state, state_n;
  logic [SRC_W-1:0] g, g_n;
  logic [SRC_W-1:0] ptr, ptr_n;
  logic [N_DRV-1:0] en_n;
  logic [SRC_W-1:0] winner;
  logic             push;
  logic             empty;
  logic [SRC_W+BUS_W-1:0] head;

  assign winner = SRC_W'(rr_pick(8'(req), 3'(ptr), N_DRV));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      en    <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
      ptr   <= ptr_n;
      en    <= en_n;
    end
  end

  always_comb begin
    state_n = state;
    g_n     = g;
    ptr_n   = ptr;
    en_n    = '0;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req && !full) begin
          g_n          = winner;
          en_n[winner] = 1'b1;
          state_n      = GRANT;
        end
      end
      GRANT: begin
        en_n[g] = 1'b1;
        state_n = SAMPLE;
      end
      SAMPLE: begin
        push    = 1'b1;
        ptr_n   = (g == SRC_W'(N_DRV-1)) ? '0 : g + 1'b1;
        state_n = TURN;
      end
      TURN: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  tribus_fifo #(
    .WIDTH(SRC_W + BUS_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (out_ready),
    .din    ({g, bus}),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

  assign out_valid = !empty;
  assign out_data  = head[BUS_W-1:0];
  assign out_src   = head[BUS_W +: SRC_W];

`ifdef TRIBUS_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_bytes <= '0;
      stat_stall <= '0;
    end else begin
      if (push && stat_bytes != 16'hFFFF)
        stat_bytes <= stat_bytes + 1'b1;
      if (state == IDLE && |req && full && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tribus_reader.sv
// Directed testbench for tribus_reader.
// Drives a modelled tristate bus from the en outputs.
module tb_tribus_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] en;
  logic [7:0] bus;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic       full;
  logic [7:0] drv [4];
  int         checks = 0;
  int         errors = 0;
`ifdef TRIBUS_READER_STATS_EN
  logic [15:0] stat_bytes;
  logic [15:0] stat_stall;
`endif

  always #5 clk = ~clk;

  always_comb begin
    bus = 8'hzz;
    for (int i = 0; i < 4; i++)
      if (en[i]) bus = drv[i];
  end

  tribus_reader #(.N_DRV(4), .DEPTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .en       (en),
    .bus      (bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src),
    .full     (full)
`ifdef TRIBUS_READER_STATS_EN
    ,
    .stat_bytes(stat_bytes),
    .stat_stall(stat_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    reset_n   = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drv[i] = 8'h00;

    // 1: reset held with all requests pending
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_en", 32'(en), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
    end
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_src", 32'(out_src), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    reset_n = 1'b1;
    req     = 4'b0000;
    tick();
    chk("idle_en", 32'(en), 32'h0);

    // 2: single grant to driver 2, req dropped after grant
    req    = 4'b0100;
    drv[2] = 8'hA5;
    tick();
    chk("t2_grant", 32'(en), 32'h4);
    req = 4'b0000;
    tick();
    chk("t2_sample", 32'(en), 32'h4);
    chk("t2_nvalid", 32'(out_valid), 32'h0);
    tick();
    chk("t2_turn", 32'(en), 32'h0);
    chk("t2_valid", 32'(out_valid), 32'h1);
    chk("t2_data", 32'(out_data), 32'hA5);
    chk("t2_src", 32'(out_src), 32'h2);
    out_ready = 1'b1;
    tick();
    chk("t2_pop", 32'(out_valid), 32'h0);
    chk("t2_hold", 32'(out_data), 32'hA5);
    chk("t2_idle", 32'(en), 32'h0);
    out_ready = 1'b0;

    // 3: round robin over all four drivers
    do_reset();
    for (int i = 0; i < 4; i++) drv[i] = 8'h10 + 8'(i);
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick();
      chk("t3_grant", 32'(en), 32'(oh));
      tick();
      chk("t3_sample", 32'(en), 32'(oh));
      tick();
      chk("t3_turn", 32'(en), 32'h0);
      chk("t3_valid", 32'(out_valid), 32'h1);
      chk("t3_data", 32'(out_data), 32'h10 + (k % 4));
      chk("t3_src", 32'(out_src), 32'(k % 4));
      if (k == 4) req = 4'b0000;
      tick();
      chk("t3_gap", 32'(en), 32'h0);
    end
    chk("t3_drain", 32'(out_valid), 32'h0);

    // 4: fill the FIFO, stall, then free one slot
    do_reset();
    out_ready = 1'b0;
    req       = 4'b0001;
    drv[0]    = 8'h3C;
    for (int i = 0; i < 15; i++) tick();
    chk("t4_full", 32'(full), 32'h1);
    chk("t4_head", 32'(out_data), 32'h3C);
    chk("t4_hsrc", 32'(out_src), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_en", 32'(en), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_unfull", 32'(full), 32'h0);
    chk("t4_valid", 32'(out_valid), 32'h1);
    tick();
    chk("t4_regrant", 32'(en), 32'h1);
    tick();
    chk("t4_sample", 32'(en), 32'h1);
    tick();
    chk("t4_refull", 32'(full), 32'h1);
    chk("t4_turn", 32'(en), 32'h0);
`ifdef TRIBUS_READER_STATS_EN
    chk("t6_bytes", 32'(stat_bytes), 32'd5);
    chk("t6_stall", 32'(stat_stall), 32'd6);
`endif

    // 5: reset during SAMPLE discards the byte
    do_reset();
    req       = 4'b0010;
    drv[1]    = 8'h77;
    out_ready = 1'b0;
    tick();
    chk("t5_grant", 32'(en), 32'h2);
    tick();
    chk("t5_sample", 32'(en), 32'h2);
    reset_n = 1'b0;
    tick();
    chk("t5_rst_en", 32'(en), 32'h0);
    chk("t5_rst_valid", 32'(out_valid), 32'h0);
    reset_n = 1'b1;
    req     = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_novalid", 32'(out_valid), 32'h0);
      chk("t5_noen", 32'(en), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
